vc_mem_arb2: RTL
================

Name: vc_mem_arb2

Overview:
- Two-requester arbiter that shares one single-port memory (vc_TestSinglePortMem-style val/rdy req/resp interface) between two clients, e.g. instruction and data ports.
- Grants at most one request per cycle, tracks the source of every in-flight request in an ID FIFO, and routes in-order memory responses back to the originating port.
- Zero-cycle combinational forwarding in both directions; the only state is arbitration priority and the ID FIFO.

Parameters:
- p_addr_sz, 16, memory request address width in bits
- p_data_sz, 32, memory data width in bits; len field width is log2(p_data_sz/8)
- p_max_outstanding, 4, ID FIFO depth (max in-flight requests); power of two, >= 2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req0_val/req0_rdy  in/out  1  port 0 request handshake
- req0_msg  in  REQ_SZ  port 0 request message (type, addr, len, data)
- req1_val/req1_rdy/req1_msg  as port 0, for port 1
- resp0_val/resp0_rdy  out/in  1  port 0 response handshake
- resp0_msg  out  RESP_SZ  port 0 response message (type, len, data)
- resp1_val/resp1_rdy/resp1_msg  as port 0, for port 1
- memreq_val/memreq_rdy  out/in  1  memory request handshake
- memreq_msg  out  REQ_SZ  forwarded request
- memresp_val/memresp_rdy  in/out  1  memory response handshake
- memresp_msg  in  RESP_SZ  memory response
- REQ_SZ = VC_MEM_REQ_MSG_SZ(p_addr_sz,p_data_sz); RESP_SZ = VC_MEM_RESP_MSG_SZ(p_data_sz)

Behaviour:
- Reset (reset==0, async): ID FIFO empty (count=0, rd/wr ptr=0), priority pointer=port 0. All val/rdy outputs low while the FIFO is empty and no request is valid.
- Grant (combinational):
  - only one port valid -> that port;
  - both valid -> port named by the priority pointer.
- Request path:
  - memreq_val = (req0_val|req1_val) & !full.
  - memreq_msg = granted port's msg, passed unmodified.
  - reqN_rdy = grantN & memreq_rdy & !full.
- Fire = memreq_val & memreq_rdy. On fire, push the granted port ID (1 bit) into the FIFO.
- Round-robin: on fire, the priority pointer moves to the port that was not granted. No fire means no change.
- Full: no grant; memreq_val=0; both req_rdy=0. A pop in the same cycle does not unblock a push (full check uses registered count).
- Response path:
  - head = FIFO head ID.
  - respN_val = memresp_val & !empty & (head==N).
  - memresp_rdy = !empty & resp[head]_rdy.
  - Both resp msgs are driven with memresp_msg.
- Pop on memresp_val & memresp_rdy.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo p_max_outstanding.
- Empty with memresp_val=1 is a protocol error: memresp_rdy=0, and the sim-only check prints an error.
- Latency: request 0 cycles; response 0 cycles. Throughput 1 req/cycle sustained when memreq_rdy=1.
- Message type (read/write/amoadd/amoand/amoor) is never decoded; AMOs are arbitrated exactly like reads and writes.
- Reset mid-operation clears the FIFO. Responses for requests issued before reset are dropped by the error rule; the memory is reset alongside the arbiter in system use.

Optional Feature:
- Macro VC_MEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports are valid; the priority pointer register is removed.
- Undefined (default): round-robin as above.
- Handshake, FIFO and routing behaviour are identical in both modes.

Decomposition:
- Message field widths, field slices, type codes and size macros come from the shared vc memory-message header (VC_MEM_REQ_MSG_*, VC_MEM_RESP_MSG_*); no new typedefs.
- Local constant c_id_ptr_sz = log2(p_max_outstanding).
- One sub-module: vc_mem_arb_id_fifo. It is a 1-bit-wide, parameterised-depth synchronous FIFO with async active-low reset and full/empty outputs.

Test Plan:
- Bench: two vc_TestRandDelaySources, one vc_TestSinglePortMem, two vc_TestRandDelaySinks; delays 0 and 3/10.
- Port 0 only: write 0x0a0b0c0d @0x0000, then read @0x0000 -> resp0 read data 0x0a0b0c0d; resp1_val never asserted.
- Both ports valid every cycle, sink delay 0: grants alternate 0,1,0,1. Port0 writes 0x11111111 @0x0020 and port1 writes 0x22222222 @0x0024; subsequent reads return the matching values on the originating port.
- AMO sharing: port0 writes 0x12345678 @0x0010; port1 amoadd 0x87654321 -> resp1 data 0x12345678; port0 read -> 0x99999999.
- Full stall: resp sinks hold rdy=0 while 5 requests are offered with p_max_outstanding=4. Exactly 4 fire, memreq_val=0 on the 5th; after one response pops, the 5th fires the next cycle.
- Async reset asserted mid-stream with 2 in flight: FIFO count=0 and memresp_rdy=0 immediately; after release, priority=port 0 and new traffic completes normally.
- VC_MEM_ARB_FIXED_PRIO_EN defined, both ports always valid with 4 reqs each: all 4 port-0 requests are granted before any port-1 request.

Source files
------------

// File: rtl/vc_mem_arb2_pkg.sv
// rtl/vc_mem_arb2_pkg.sv - vc memory-message field sizes and type codes
package vc_mem_arb2_pkg;

    localparam int unsigned c_mem_type_sz = 3;

    localparam logic [2:0] c_mem_type_read   = 3'd0;
    localparam logic [2:0] c_mem_type_write  = 3'd1;
    localparam logic [2:0] c_mem_type_amoadd = 3'd2;
    localparam logic [2:0] c_mem_type_amoand = 3'd3;
    localparam logic [2:0] c_mem_type_amoor  = 3'd4;

    function automatic int unsigned vc_mem_len_sz(input int unsigned data_sz);
        return $clog2(data_sz / 8);
    endfunction

    // Request layout, MSB first: {type, addr, len, data}
    function automatic int unsigned vc_mem_req_msg_sz(input int unsigned addr_sz,
                                                      input int unsigned data_sz);
        return c_mem_type_sz + addr_sz + vc_mem_len_sz(data_sz) + data_sz;
    endfunction

    // Response layout, MSB first: {type, len, data}
    function automatic int unsigned vc_mem_resp_msg_sz(input int unsigned data_sz);
        return c_mem_type_sz + vc_mem_len_sz(data_sz) + data_sz;
    endfunction

endpackage

// File: rtl/vc_mem_arb_id_fifo.sv
// rtl/vc_mem_arb_id_fifo.sv - 1-bit source-ID FIFO of 2**p_ptr_sz entries
module vc_mem_arb_id_fifo #(
    parameter int unsigned p_ptr_sz = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head_id,
    output logic full,
    output logic empty
);

    localparam int unsigned c_depth = 1 << p_ptr_sz;
    localparam logic [p_ptr_sz:0] c_full_count = (p_ptr_sz + 1)'(c_depth);

    logic                ids [c_depth];
    logic [p_ptr_sz-1:0] wr_ptr;
    logic [p_ptr_sz-1:0] rd_ptr;
    logic [p_ptr_sz:0]   count;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == c_full_count);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_id = ids[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            ids[wr_ptr] <= push_id;
        end
    end

    // Depth is a power of two, so pointers wrap by plain overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vc_mem_arb2.sv
// rtl/vc_mem_arb2.sv - two-port arbiter onto one memory; VC_MEM_ARB_FIXED_PRIO_EN selects fixed priority
module vc_mem_arb2
    import vc_mem_arb2_pkg::*;
#(
    parameter int unsigned p_addr_sz         = 16,
    parameter int unsigned p_data_sz         = 32,
    parameter int unsigned p_max_outstanding = 4,
    localparam int unsigned REQ_SZ  = vc_mem_req_msg_sz(p_addr_sz, p_data_sz),
    localparam int unsigned RESP_SZ = vc_mem_resp_msg_sz(p_data_sz)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_val,
    output logic               req0_rdy,
    input  logic [REQ_SZ-1:0]  req0_msg,
    input  logic               req1_val,
    output logic               req1_rdy,
    input  logic [REQ_SZ-1:0]  req1_msg,
    output logic               resp0_val,
    input  logic               resp0_rdy,
    output logic [RESP_SZ-1:0] resp0_msg,
    output logic               resp1_val,
    input  logic               resp1_rdy,
    output logic [RESP_SZ-1:0] resp1_msg,
    output logic               memreq_val,
    input  logic               memreq_rdy,
    output logic [REQ_SZ-1:0]  memreq_msg,
    input  logic               memresp_val,
    output logic               memresp_rdy,
    input  logic [RESP_SZ-1:0] memresp_msg
);

    localparam int unsigned c_id_ptr_sz = $clog2(p_max_outstanding);

    logic prio;
    logic grant0;
    logic grant1;
    logic full;
    logic empty;
    logic head;
    logic fire;
    logic pop;

`ifdef VC_MEM_ARB_FIXED_PRIO_EN
    assign prio = 1'b0;
`else
    // Points at the port that wins the next two-way contention
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio <= 1'b0;
        end else if (fire) begin
            prio <= ~grant1;
        end
    end
`endif

    always_comb begin
        grant0 = ~full & req0_val & (~req1_val | ~prio);
        grant1 = ~full & req1_val & (~req0_val |  prio);
    end

    assign memreq_val = (req0_val | req1_val) & ~full;
    assign memreq_msg = grant1 ? req1_msg : req0_msg;
    assign req0_rdy   = grant0 & memreq_rdy & ~full;
    assign req1_rdy   = grant1 & memreq_rdy & ~full;
    assign fire       = memreq_val & memreq_rdy;

    // Responses return in issue order, so the FIFO head names their owner
    assign resp0_val   = memresp_val & ~empty & ~head;
    assign resp1_val   = memresp_val & ~empty &  head;
    assign resp0_msg   = memresp_msg;
    assign resp1_msg   = memresp_msg;
    assign memresp_rdy = ~empty & (head ? resp1_rdy : resp0_rdy);
    assign pop         = memresp_val & memresp_rdy;

    vc_mem_arb_id_fifo #(
        .p_ptr_sz (c_id_ptr_sz)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fire),
        .push_id (grant1),
        .pop     (pop),
        .head_id (head),
        .full    (full),
        .empty   (empty)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && memresp_val && empty) begin
            $error("vc_mem_arb2: memory response with no request in flight");
        end
    end
`endif

endmodule
